// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO types, mode constants and pointer helpers.
package fifo_pkg;
  typedef int unsigned fifo_width_t;
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;
  function automatic fifo_width_t level_w(input int depth);
    return fifo_width_t'($clog2(depth + 1));
  endfunction
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage, one write port, combinational read port.
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO, any depth, standard or show-ahead read,
// exact flags from a registered level, flush and sticky error flags.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_STD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = int'(level_w(DEPTH));
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("param_sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
  end
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             wr_ok, rd_ok;
  assign full         = level == LW'(DEPTH);
  assign empty        = level == '0;
  assign almost_full  = level >= LW'(AF_LEVEL);
  assign almost_empty = level <= LW'(AE_LEVEL);
  // full/empty gate each side on its own, so a same-cycle read never frees room for a write
  assign wr_ok = wr_en && !full && !flush;
  assign rd_ok = rd_en && !empty && !flush;
  fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PW(PW)) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_ok) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
        if (rd_ok) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
        level <= (wr_ok && !rd_ok) ? level + 1'b1 : (rd_ok && !wr_ok) ? level - 1'b1 : level;
      end
      overflow  <= (wr_en && full && !flush) || (overflow && !clr_err);
      underflow <= (rd_en && empty && !flush) || (underflow && !clr_err);
    end
  end
  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign dout = rd_data;
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout <= '0;
      else if (rd_ok) dout <= rd_data;
    end
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard bench over three FIFO configurations.
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_wr = 0, a_rd = 0, a_fl = 0, a_ce = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [2:0] a_level;
  param_sync_fifo #(.DEPTH(5), .WIDTH(8), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr), .din(a_din), .rd_en(a_rd), .flush(a_fl),
    .clr_err(a_ce), .dout(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .level(a_level), .overflow(a_ov), .underflow(a_un));

  logic       b_wr = 0, b_rd = 0, b_fl = 0, b_ce = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [4:0] b_level;
  param_sync_fifo #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr), .din(b_din), .rd_en(b_rd), .flush(b_fl),
    .clr_err(b_ce), .dout(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .level(b_level), .overflow(b_ov), .underflow(b_un));

  logic       c_wr = 0, c_rd = 0, c_fl = 0, c_ce = 0;
  logic [7:0] c_din = 0, c_dout;
  logic       c_full, c_empty, c_af, c_ae, c_ov, c_un;
  logic [2:0] c_level;
  param_sync_fifo #(.DEPTH(4), .WIDTH(8), .FWFT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(c_wr), .din(c_din), .rd_en(c_rd), .flush(c_fl),
    .clr_err(c_ce), .dout(c_dout), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .level(c_level), .overflow(c_ov), .underflow(c_un));

  int errors = 0;
  int checks = 0;
  logic [7:0] qa[$], qb[$], qc[$];
  logic [7:0] exp_d;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (a_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", a_level); end
    checks++; if ({a_empty, a_full, a_ae, a_af} !== 4'b1010) begin errors++; $display("FAIL reset_flags got=%b exp=1010", {a_empty, a_full, a_ae, a_af}); end
    checks++; if ({a_ov, a_un} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {a_ov, a_un}); end
    checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", a_dout); end
    checks++; if ({c_empty, c_level} !== {1'b1, 3'd0}) begin errors++; $display("FAIL reset_fwft got=%b/%0d exp=1/0", c_empty, c_level); end
  endtask

  task automatic a_read_check(input string name);
    a_rd = 1; tick; a_rd = 0;
    exp_d = qa.pop_front();
    checks++; if (a_dout !== exp_d) begin errors++; $display("FAIL %s got=%h exp=%h", name, a_dout, exp_d); end
  endtask

  task automatic test_wrap;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        a_wr = 1; a_din = 8'(1 + 5 * r + i); qa.push_back(a_din); tick;
      end
      a_wr = 0;
      checks++; if ({a_full, a_level} !== {1'b1, 3'd5}) begin errors++; $display("FAIL wrap_full got=%b/%0d exp=1/5", a_full, a_level); end
      for (int i = 0; i < 5; i++) a_read_check("wrap_data");
      checks++; if ({a_empty, a_level} !== {1'b1, 3'd0}) begin errors++; $display("FAIL wrap_empty got=%b/%0d exp=1/0", a_empty, a_level); end
    end
  endtask

  task automatic test_errors;
    for (int i = 0; i < 6; i++) begin
      a_wr = 1; a_din = 8'h20 + 8'(i);
      if (i < 5) qa.push_back(a_din);
      tick;
    end
    a_wr = 0;
    checks++; if ({a_ov, a_level} !== {1'b1, 3'd5}) begin errors++; $display("FAIL overflow got=%b/%0d exp=1/5", a_ov, a_level); end
    for (int i = 0; i < 5; i++) a_read_check("ovf_data");
    checks++; if (a_un !== 1'b0) begin errors++; $display("FAIL underflow_early got=%b exp=0", a_un); end
    a_rd = 1; tick; a_rd = 0;
    checks++; if ({a_un, a_level} !== {1'b1, 3'd0}) begin errors++; $display("FAIL underflow got=%b/%0d exp=1/0", a_un, a_level); end
    checks++; if (a_dout !== 8'h24) begin errors++; $display("FAIL underflow_dout got=%h exp=24", a_dout); end
    tick;
    checks++; if ({a_ov, a_un} !== 2'b11) begin errors++; $display("FAIL err_sticky got=%b exp=11", {a_ov, a_un}); end
    a_ce = 1; tick; a_ce = 0;
    checks++; if ({a_ov, a_un} !== 2'b00) begin errors++; $display("FAIL clr_err got=%b exp=00", {a_ov, a_un}); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 3; i++) begin
      a_wr = 1; a_din = 8'h40 + 8'(i); qa.push_back(a_din); tick;
    end
    for (int i = 0; i < 4; i++) begin
      a_wr = 1; a_rd = 1; a_din = 8'h50 + 8'(i); qa.push_back(a_din); tick;
      exp_d = qa.pop_front();
      checks++; if (a_dout !== exp_d) begin errors++; $display("FAIL simul_data got=%h exp=%h", a_dout, exp_d); end
      checks++; if (a_level !== 3'd3) begin errors++; $display("FAIL simul_level got=%0d exp=3", a_level); end
    end
    a_rd = 0;
    for (int i = 0; i < 2; i++) begin
      a_din = 8'h60 + 8'(i); qa.push_back(a_din); tick;
    end
    a_din = 8'h77; a_rd = 1; tick; a_wr = 0; a_rd = 0;
    exp_d = qa.pop_front();
    checks++; if (a_dout !== exp_d) begin errors++; $display("FAIL full_rw_data got=%h exp=%h", a_dout, exp_d); end
    checks++; if ({a_level, a_ov} !== {3'd4, 1'b1}) begin errors++; $display("FAIL full_rw got=%0d/%b exp=4/1", a_level, a_ov); end
    while (qa.size() > 0) a_read_check("full_rw_drain");
  endtask

  task automatic test_fwft;
    c_wr = 1; c_din = 8'hA5; qc.push_back(c_din); tick; c_wr = 0;
    checks++; if ({c_empty, c_dout} !== {1'b0, 8'hA5}) begin errors++; $display("FAIL fwft_show got=%b/%h exp=0/a5", c_empty, c_dout); end
    for (int i = 0; i < 3; i++) begin
      c_wr = 1; c_din = 8'h3C ^ 8'(i * 17); qc.push_back(c_din); tick;
    end
    c_wr = 0;
    while (qc.size() > 0) begin
      exp_d = qc.pop_front();
      checks++; if (c_dout !== exp_d) begin errors++; $display("FAIL fwft_data got=%h exp=%h", c_dout, exp_d); end
      c_rd = 1; tick; c_rd = 0;
    end
    checks++; if ({c_empty, c_level} !== {1'b1, 3'd0}) begin errors++; $display("FAIL fwft_empty got=%b/%0d exp=1/0", c_empty, c_level); end
  endtask

  task automatic test_thresholds_flush;
    for (int i = 0; i < 14; i++) begin
      b_wr = 1; b_din = 8'h80 + 8'(i); qb.push_back(b_din); tick;
      if (i == 12) begin
        checks++; if (b_af !== 1'b0) begin errors++; $display("FAIL af_13 got=%b exp=0", b_af); end
      end
    end
    b_wr = 0;
    checks++; if ({b_af, b_full, b_level} !== {2'b10, 5'd14}) begin errors++; $display("FAIL af_14 got=%b%b/%0d exp=10/14", b_af, b_full, b_level); end
    for (int i = 0; i < 12; i++) begin
      b_rd = 1; tick; b_rd = 0;
      exp_d = qb.pop_front();
      checks++; if (b_dout !== exp_d) begin errors++; $display("FAIL thr_data got=%h exp=%h", b_dout, exp_d); end
      if (i == 10) begin
        checks++; if ({b_ae, b_level} !== {1'b0, 5'd3}) begin errors++; $display("FAIL ae_3 got=%b/%0d exp=0/3", b_ae, b_level); end
      end
    end
    checks++; if ({b_ae, b_level} !== {1'b1, 5'd2}) begin errors++; $display("FAIL ae_2 got=%b/%0d exp=1/2", b_ae, b_level); end
    b_fl = 1; b_wr = 1; b_din = 8'hEE; tick; b_fl = 0; b_wr = 0;
    qb.delete();
    checks++; if ({b_empty, b_level} !== {1'b1, 5'd0}) begin errors++; $display("FAIL flush got=%b/%0d exp=1/0", b_empty, b_level); end
    checks++; if (b_dout !== 8'h8B) begin errors++; $display("FAIL flush_dout got=%h exp=8b", b_dout); end
    checks++; if ({b_ov, b_un} !== 2'b00) begin errors++; $display("FAIL flush_err got=%b exp=00", {b_ov, b_un}); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 7; i++) begin
      b_wr = 1; b_din = 8'h90 + 8'(i); tick;
    end
    b_wr = 0;
    b_rd = 1; tick; b_rd = 0;
    b_wr = 1; b_din = 8'h99; tick; b_wr = 0;
    checks++; if ({b_level, b_dout} !== {5'd7, 8'h90}) begin errors++; $display("FAIL pre_reset got=%0d/%h exp=7/90", b_level, b_dout); end
    #2 rst_n = 0;
    #1;
    checks++; if ({b_level, b_empty, b_full, b_ae, b_af, b_dout} !== {5'd0, 4'b1010, 8'h00}) begin
      errors++; $display("FAIL mid_reset got=%0d/%b%b%b%b/%h exp=0/1010/00", b_level, b_empty, b_full, b_ae, b_af, b_dout);
    end
    #3 rst_n = 1;
    b_wr = 1; b_din = 8'h11; tick; b_wr = 0;
    checks++; if (b_level !== 5'd1) begin errors++; $display("FAIL post_reset_write got=%0d exp=1", b_level); end
  endtask

  initial begin
    #12 rst_n = 1;
    #1;
    test_reset();
    test_wrap();
    test_errors();
    test_simultaneous();
    test_fwft();
    test_thresholds_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
